// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller.
// Frame: sync, address, 4 data bytes LSB-first, optional checksum.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_COMMIT
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         NUM_REGS  = 4;

  localparam logic [1:0] ADDR_FREQ = 2'd0;
  localparam logic [1:0] ADDR_GAIN = 2'd1;
  localparam logic [1:0] ADDR_FILT = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  function automatic logic addr_ok(input logic [7:0] a);
    return a < 8'(NUM_REGS);
  endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Inter-byte idle counter; pulses o_Expire on the cycle the count
// reaches LIMIT-1. A clear always wins over expiry.
module cmd_timeout #(
  parameter int LIMIT = 118100
) (
  input  logic osc_clk,
  input  logic i_Rst,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expire
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last   = (r_cnt == W'(LIMIT - 1));
  assign o_Expire = i_Enable && !i_Clear && w_last;

  always_ff @(posedge osc_clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_cnt <= '0;
    end else if (i_Clear || !i_Enable) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART register-write command controller (4 x 32-bit registers).
// Define UART_CMD_CHECKSUM_EN to add the trailing XOR checksum byte.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int          TIMEOUT_CLKS  = 118100,
  parameter logic [31:0] FREQ_WORD_RST = 32'h0000_0000
) (
  input  logic        osc_clk,
  input  logic        i_Rst,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [31:0] o_Freq_Word,
  output logic [31:0] o_Gain,
  output logic [31:0] o_Filt_Cfg,
  output logic [31:0] o_Ctrl,
  output logic [3:0]  o_Wr_Strobe,
  output logic        o_Cmd_Ok,
  output logic        o_Cmd_Err,
  output logic        o_Busy
);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_addr;
  logic [31:0] r_shift;
  logic [1:0]  r_cnt;
  logic [31:0] r_regs [NUM_REGS];
  logic [3:0]  r_strobe;
  logic        r_ok;
  logic        r_err;
  logic        w_expire;
  logic        w_to;
  logic        w_valid;

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]  r_csum;
  logic        r_csum_ok;
  assign w_valid = addr_ok(r_addr) && r_csum_ok;
`else
  assign w_valid = addr_ok(r_addr);
`endif

  cmd_timeout #(
    .LIMIT (TIMEOUT_CLKS)
  ) u_timeout (
    .osc_clk  (osc_clk),
    .i_Rst    (i_Rst),
    .i_Clear  (i_Rx_DV),
    .i_Enable (r_state != S_IDLE),
    .o_Expire (w_expire)
  );

  // Commit is a single fixed cycle, so an expiry there is meaningless.
  assign w_to = w_expire && (r_state != S_COMMIT);

  always_ff @(posedge osc_clk or posedge i_Rst) begin
    if (i_Rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) w_next = S_ADDR;
      end
      S_ADDR: begin
        if (i_Rx_DV)   w_next = S_DATA;
        else if (w_to) w_next = S_IDLE;
      end
      S_DATA: begin
        if (i_Rx_DV) begin
          if (r_cnt == 2'd3) begin
`ifdef UART_CMD_CHECKSUM_EN
            w_next = S_CSUM;
`else
            w_next = S_COMMIT;
`endif
          end
        end else if (w_to) begin
          w_next = S_IDLE;
        end
      end
      S_CSUM: begin
        if (i_Rx_DV)   w_next = S_COMMIT;
        else if (w_to) w_next = S_IDLE;
      end
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge osc_clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_addr  <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_Rx_DV) begin
      if (r_state == S_ADDR) begin
        r_addr <= i_Rx_Byte;
        r_cnt  <= '0;
      end else if (r_state == S_DATA) begin
        r_shift <= {i_Rx_Byte, r_shift[31:8]};
        r_cnt   <= r_cnt + 2'd1;
      end
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  always_ff @(posedge osc_clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_csum    <= '0;
      r_csum_ok <= 1'b0;
    end else if (i_Rx_DV) begin
      if (r_state == S_ADDR)      r_csum    <= i_Rx_Byte;
      else if (r_state == S_DATA) r_csum    <= r_csum ^ i_Rx_Byte;
      else if (r_state == S_CSUM) r_csum_ok <= (i_Rx_Byte == r_csum);
    end
  end
`endif

  always_ff @(posedge osc_clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_regs[ADDR_FREQ] <= FREQ_WORD_RST;
      r_strobe <= '0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_strobe <= '0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
      if (r_state == S_COMMIT) begin
        if (w_valid) begin
          r_regs[r_addr[1:0]] <= r_shift;
          r_strobe <= 4'b0001 << r_addr[1:0];
          r_ok     <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end else if (w_to) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_Freq_Word = r_regs[ADDR_FREQ];
  assign o_Gain      = r_regs[ADDR_GAIN];
  assign o_Filt_Cfg  = r_regs[ADDR_FILT];
  assign o_Ctrl      = r_regs[ADDR_CTRL];
  assign o_Wr_Strobe = r_strobe;
  assign o_Cmd_Ok    = r_ok;
  assign o_Cmd_Err   = r_err;
  assign o_Busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized self-checking bench for uart_cmd_ctrl.
// Reference model: 4-entry register array updated per whole frame.
module tb_uart_cmd_ctrl;

  localparam int          TO   = 40;
  localparam logic [31:0] FRST = 32'hDEAD_BEEF;
`ifdef UART_CMD_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        osc_clk = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_Rx_DV = 1'b0;
  logic [7:0]  i_Rx_Byte = 8'h00;
  logic [31:0] o_Freq_Word, o_Gain, o_Filt_Cfg, o_Ctrl;
  logic [3:0]  o_Wr_Strobe;
  logic        o_Cmd_Ok, o_Cmd_Err, o_Busy;

  int checks = 0;
  int errors = 0;
  int n_ok = 0;
  int n_err = 0;
  int n_both = 0;
  logic [31:0] m_regs [4];

  uart_cmd_ctrl #(
    .TIMEOUT_CLKS  (TO),
    .FREQ_WORD_RST (FRST)
  ) dut (
    .osc_clk     (osc_clk),
    .i_Rst       (i_Rst),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .o_Freq_Word (o_Freq_Word),
    .o_Gain      (o_Gain),
    .o_Filt_Cfg  (o_Filt_Cfg),
    .o_Ctrl      (o_Ctrl),
    .o_Wr_Strobe (o_Wr_Strobe),
    .o_Cmd_Ok    (o_Cmd_Ok),
    .o_Cmd_Err   (o_Cmd_Err),
    .o_Busy      (o_Busy)
  );

  always #5 osc_clk = ~osc_clk;

  always @(posedge osc_clk) begin
    if (o_Cmd_Ok) n_ok++;
    if (o_Cmd_Err) n_err++;
    if (o_Cmd_Ok && o_Cmd_Err) n_both++;
  end

  task automatic model_reset();
    m_regs[0] = FRST;
    for (int i = 1; i < 4; i++) m_regs[i] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge osc_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(posedge osc_clk);
    #1;
    i_Rx_DV = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] act [4];
    act[0] = o_Freq_Word;
    act[1] = o_Gain;
    act[2] = o_Filt_Cfg;
    act[3] = o_Ctrl;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act[i] !== m_regs[i]) begin
        errors++;
        $display("FAIL %s reg%0d: got %h want %h", tag, i, act[i], m_regs[i]);
      end
    end
  endtask

  // stall: idle cycles after the address byte (-1 = random small gap)
  task automatic do_frame(input string tag, input logic [7:0] addr,
                          input logic [31:0] data, input bit bad,
                          input int garbage, input int stall);
    logic [7:0] q [$];
    logic [7:0] cs;
    logic [7:0] b;
    logic [3:0] exp_stb;
    bit exp_ok;
    int ok0, err0;
    ok0  = n_ok;
    err0 = n_err;
    for (int i = 0; i < garbage; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      q.push_back(b);
    end
    q.push_back(8'hA5);
    q.push_back(addr);
    cs = addr;
    for (int i = 0; i < 4; i++) begin
      b = data[8*i +: 8];
      q.push_back(b);
      cs = cs ^ b;
    end
    if (CSUM_EN) q.push_back(bad ? (cs ^ 8'h5A) : cs);
    exp_ok  = (addr < 8'd4) && !(CSUM_EN && bad);
    exp_stb = exp_ok ? (4'b0001 << addr[1:0]) : 4'b0000;
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (i == garbage + 1 && stall >= 0) idle(stall);
      else if (i != q.size() - 1) idle($urandom_range(0, 3));
    end
    checks++;
    if (o_Wr_Strobe !== 4'b0 || o_Cmd_Ok !== 1'b0 || o_Cmd_Err !== 1'b0) begin
      errors++;
      $display("FAIL %s early: stb=%b ok=%b err=%b want 0", tag,
               o_Wr_Strobe, o_Cmd_Ok, o_Cmd_Err);
    end
    idle(1);
    if (exp_ok) m_regs[addr[1:0]] = data;
    checks++;
    if (o_Wr_Strobe !== exp_stb || o_Cmd_Ok !== exp_ok || o_Cmd_Err !== !exp_ok) begin
      errors++;
      $display("FAIL %s result: stb=%b ok=%b err=%b want stb=%b ok=%b err=%b",
               tag, o_Wr_Strobe, o_Cmd_Ok, o_Cmd_Err, exp_stb, exp_ok, !exp_ok);
    end
    check_regs(tag);
    idle(1);
    checks++;
    if (o_Wr_Strobe !== 4'b0 || o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after: stb=%b busy=%b want 0", tag, o_Wr_Strobe, o_Busy);
    end
    checks++;
    if (n_ok - ok0 != int'(exp_ok) || n_err - err0 != int'(!exp_ok)) begin
      errors++;
      $display("FAIL %s pulses: ok=%0d err=%0d want ok=%0d err=%0d", tag,
               n_ok - ok0, n_err - err0, int'(exp_ok), int'(!exp_ok));
    end
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    idle(3);
    model_reset();
    checks++;
    if (o_Wr_Strobe !== 4'b0 || o_Cmd_Ok !== 1'b0 || o_Cmd_Err !== 1'b0 || o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset outs: stb=%b ok=%b err=%b busy=%b want 0",
               o_Wr_Strobe, o_Cmd_Ok, o_Cmd_Err, o_Busy);
    end
    check_regs("reset");
    i_Rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    do_frame("basic", 8'h00, 32'h1234_5678, 1'b0, 0, -1);
  endtask

  task automatic test_bad_csum();
    do_frame("bad_csum", 8'h01, 32'h1234_5678, 1'b1, 0, -1);
  endtask

  task automatic test_bad_addr();
    do_frame("bad_addr", 8'h05, 32'h1234_5678, 1'b0, 0, -1);
  endtask

  task automatic test_timeout();
    int n;
    int err0;
    err0 = n_err;
    send_byte(8'hA5);
    idle(2);
    send_byte(8'h02);
    n = 0;
    while (n < 3 * TO && o_Cmd_Err !== 1'b1) begin
      idle(1);
      n++;
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout delay: got %0d cycles want %0d", n, TO);
    end
    checks++;
    if (o_Busy !== 1'b0 || o_Wr_Strobe !== 4'b0) begin
      errors++;
      $display("FAIL timeout state: busy=%b stb=%b want 0", o_Busy, o_Wr_Strobe);
    end
    check_regs("timeout");
    idle(2);
    checks++;
    if (n_err - err0 != 1) begin
      errors++;
      $display("FAIL timeout pulses: got %0d want 1", n_err - err0);
    end
    do_frame("after_to", 8'h02, $urandom, 1'b0, 0, -1);
  endtask

  task automatic test_byte_wins();
    do_frame("byte_wins", 8'h01, $urandom, 1'b0, 0, TO - 1);
  endtask

  task automatic test_garbage_sync();
    do_frame("garbage", 8'h03, $urandom, 1'b0, 2, -1);
  endtask

  task automatic test_mid_reset();
    int ok0, err0;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h78);
    #2;
    i_Rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (o_Busy !== 1'b0 || o_Wr_Strobe !== 4'b0 || o_Cmd_Ok !== 1'b0 || o_Cmd_Err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset outs: busy=%b stb=%b ok=%b err=%b want 0",
               o_Busy, o_Wr_Strobe, o_Cmd_Ok, o_Cmd_Err);
    end
    check_regs("mid_reset");
    idle(2);
    i_Rst = 1'b0;
    idle(1);
    ok0  = n_ok;
    err0 = n_err;
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    if (CSUM_EN) send_byte(8'h08);
    idle(TO + 5);
    checks++;
    if (n_ok != ok0 || n_err != err0 || o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset tail: ok=%0d err=%0d busy=%b want 0 0 0",
               n_ok - ok0, n_err - err0, o_Busy);
    end
    check_regs("mid_reset_tail");
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0]  a;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom_range(0, 5));
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d[15:8] = 8'hA5;
      do_frame("random", a, d, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_frame("b2b", 8'(i), $urandom, 1'b0, 0, 0);
  endtask

  initial begin
    model_reset();
    idle(1);
    test_reset();
    test_basic();
    test_bad_csum();
    test_bad_addr();
    test_timeout();
    test_byte_wins();
    test_garbage_sync();
    test_mid_reset();
    test_random();
    test_back_to_back();
    checks++;
    if (n_both != 0) begin
      errors++;
      $display("FAIL ok_err_overlap: got %0d cycles want 0", n_both);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
